// File: rtl/demux_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_router_pkg
//  Brief    : Shared constants and helpers for the demux_router slice:
//             legal parameter ranges, channel one-hot encoding and
//             round-robin pointer wrap.
//  Revision : 1.0  initial release
// ============================================================================
package demux_router_pkg;

    // Legal parameter ranges for the router.
    localparam int unsigned c_NUM_CH_MIN = 2;
    localparam int unsigned c_NUM_CH_MAX = 32;
    localparam int unsigned c_WIDTH_MIN  = 1;
    localparam int unsigned c_WIDTH_MAX  = 32;

    // One-hot vector for a channel index, sized for the largest channel count.
    function automatic logic [31:0] onehot_vec(input logic [4:0] idx);
        logic [31:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Next round-robin pointer: steps by one and wraps from num_ch-1 to 0.
    function automatic logic [4:0] rr_wrap(input logic [4:0] ptr, input logic [5:0] num_ch);
        if ({1'b0, ptr} >= (num_ch - 6'd1)) begin
            return 5'd0;
        end
        return ptr + 5'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module   : demux_onehot_dec
//  Brief    : Index-to-one-hot decoder with enable. An index at or above
//             NUM_CH, or a low enable, yields an all-zero vector, so the
//             output doubles as "write accepted" when OR-reduced.
//  Revision : 1.0  initial release
// ============================================================================
module demux_onehot_dec
    import demux_router_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3
) (
    input  logic [SEL_W-1:0]  i_idx,
    input  logic              i_en,
    output logic [NUM_CH-1:0] o_onehot
);

    logic [31:0] w_full;
    logic        w_in_range;

    // Decode the index and suppress it when disabled or out of range.
    always_comb begin
        w_full     = onehot_vec(5'(i_idx));
        w_in_range = ({1'b0, i_idx} < (SEL_W + 1)'(NUM_CH));
        o_onehot   = (i_en && w_in_range) ? w_full[NUM_CH-1:0] : '0;
    end

    // Bits above the channel count are never routed anywhere.
    if (NUM_CH < 32) begin : g_spare
        logic w_unused_hi;
        assign w_unused_hi = ^w_full[31:NUM_CH];
    end

endmodule
`default_nettype wire

// File: rtl/demux_router.sv
`default_nettype none
// ============================================================================
//  Module   : demux_router
//  Brief    : Registered 1-to-NUM_CH demultiplexer feeding the ADSR envelope
//             bank. Routes each accepted WIDTH-bit write to one channel,
//             chosen by explicit select or a round-robin pointer, with a
//             one-cycle strobe and hold/clear handling of the other channels.
//  Config   : DEMUX_ROUTER_SEL_ERR_EN adds the sticky sel_err output.
//  Revision : 1.0  initial release
// ============================================================================
module demux_router
    import demux_router_pkg::*;
#(
    parameter  int NUM_CH = 8,
    parameter  int WIDTH  = 1,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    rr_en,
    input  logic                    hold_en,
    input  logic                    clr,
`ifdef DEMUX_ROUTER_SEL_ERR_EN
    output logic                    sel_err,
`endif
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_strb,
    output logic [SEL_W-1:0]        rr_ptr
);

    logic [SEL_W-1:0]  w_target;
    logic              w_wr_req;
    logic [NUM_CH-1:0] w_wr_onehot;
    logic              w_accept;
    logic [SEL_W-1:0]  r_rr_ptr;
    logic [NUM_CH-1:0] r_strb;

    // clr blocks the write so a same-cycle request never reaches a channel.
    assign w_target = rr_en ? r_rr_ptr : sel;
    assign w_wr_req = in_valid & ~clr;
    assign w_accept = |w_wr_onehot;

    // One decoder drives both the channel write enables and the strobe.
    demux_onehot_dec #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_dec (
        .i_idx    (w_target),
        .i_en     (w_wr_req),
        .o_onehot (w_wr_onehot)
    );

    // Strobe marks the channel written on the previous edge, else zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_strb <= '0;
        end else begin
            r_strb <= w_wr_onehot;
        end
    end

    // Round-robin pointer advances only on accepted round-robin writes.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_rr_ptr <= '0;
        end else if (w_accept && rr_en) begin
            r_rr_ptr <= SEL_W'(rr_wrap(5'(r_rr_ptr), 6'(NUM_CH)));
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [WIDTH-1:0] r_data;

        // Target loads the sample; others hold or zero according to hold_en.
        always_ff @(posedge clk) begin
            if (rst || clr) begin
                r_data <= '0;
            end else if (w_accept) begin
                if (w_wr_onehot[k]) begin
                    r_data <= in_data;
                end else if (!hold_en) begin
                    r_data <= '0;
                end
            end
        end

        assign out_data[k*WIDTH +: WIDTH] = r_data;
    end

`ifdef DEMUX_ROUTER_SEL_ERR_EN
    logic r_sel_err;

    // Sticky flag for explicit selects beyond the last channel; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else if (in_valid && !clr && !rr_en &&
                     ({1'b0, sel} >= (SEL_W + 1)'(NUM_CH))) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;
`endif

    assign out_strb = r_strb;
    assign rr_ptr   = r_rr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_demux_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_router
//  Brief    : Scoreboard bench for demux_router. Two instances: 8 channels x
//             1 bit and 6 channels x 4 bits. Drivers push hand-computed
//             expected state; a monitor pops and compares after each edge.
//  Config   : DEMUX_ROUTER_SEL_ERR_EN also checks sel_err.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_router;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  strb;
        logic [2:0]  ptr;
        logic        err;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8 x 1 instance
    logic       d8_rst, d8_valid, d8_rr, d8_hold, d8_clr;
    logic [0:0] d8_data;
    logic [2:0] d8_sel;
    logic [7:0] d8_out_data, d8_out_strb;
    logic [2:0] d8_rr_ptr;
    logic       d8_err;

    // 6 x 4 instance
    logic        d6_rst, d6_valid, d6_rr, d6_hold, d6_clr;
    logic [3:0]  d6_data;
    logic [2:0]  d6_sel;
    logic [23:0] d6_out_data;
    logic [5:0]  d6_out_strb;
    logic [2:0]  d6_rr_ptr;
    logic        d6_err;

    exp_t q8[$];
    exp_t q6[$];
    int   errors = 0;
    int   checks = 0;

    logic [23:0] c_rr_data [0:6];
    logic [5:0]  c_rr_strb [0:6];
    logic [2:0]  c_rr_ptr  [0:6];

    demux_router #(.NUM_CH(8), .WIDTH(1)) u_dut8 (
        .clk      (clk),
        .rst      (d8_rst),
        .in_valid (d8_valid),
        .in_data  (d8_data),
        .sel      (d8_sel),
        .rr_en    (d8_rr),
        .hold_en  (d8_hold),
        .clr      (d8_clr),
`ifdef DEMUX_ROUTER_SEL_ERR_EN
        .sel_err  (d8_err),
`endif
        .out_data (d8_out_data),
        .out_strb (d8_out_strb),
        .rr_ptr   (d8_rr_ptr)
    );

    demux_router #(.NUM_CH(6), .WIDTH(4)) u_dut6 (
        .clk      (clk),
        .rst      (d6_rst),
        .in_valid (d6_valid),
        .in_data  (d6_data),
        .sel      (d6_sel),
        .rr_en    (d6_rr),
        .hold_en  (d6_hold),
        .clr      (d6_clr),
`ifdef DEMUX_ROUTER_SEL_ERR_EN
        .sel_err  (d6_err),
`endif
        .out_data (d6_out_data),
        .out_strb (d6_out_strb),
        .rr_ptr   (d6_rr_ptr)
    );

`ifndef DEMUX_ROUTER_SEL_ERR_EN
    assign d8_err = 1'b0;
    assign d6_err = 1'b0;
`endif

    // Drive one cycle of the 8-channel instance and queue its expected state.
    task automatic step8(input logic v, input logic d, input logic [2:0] s,
                         input logic rr, input logic hold, input logic c, input logic r,
                         input logic [7:0] ed, input logic [7:0] es, input logic [2:0] ep,
                         input string nm);
        exp_t e;
        @(negedge clk);
        d8_valid = v; d8_data = d; d8_sel = s; d8_rr = rr;
        d8_hold = hold; d8_clr = c; d8_rst = r;
        d6_valid = 1'b0; d6_clr = 1'b0;
        e.data = 32'(ed); e.strb = es; e.ptr = ep; e.err = 1'b0; e.name = nm;
        q8.push_back(e);
    endtask

    // Drive one cycle of the 6-channel instance and queue its expected state.
    task automatic step6(input logic v, input logic [3:0] d, input logic [2:0] s,
                         input logic rr, input logic hold, input logic c, input logic r,
                         input logic [23:0] ed, input logic [5:0] es, input logic [2:0] ep,
                         input logic eerr, input string nm);
        exp_t e;
        @(negedge clk);
        d6_valid = v; d6_data = d; d6_sel = s; d6_rr = rr;
        d6_hold = hold; d6_clr = c; d6_rst = r;
        d8_valid = 1'b0; d8_clr = 1'b0;
        e.data = 32'(ed); e.strb = 8'(es); e.ptr = ep; e.err = eerr; e.name = nm;
        q6.push_back(e);
    endtask

    // Monitor: compare each instance against its queue just after the edge.
    always @(posedge clk) begin
        exp_t e;
        logic ce;
        #1;
        if (q8.size() > 0) begin
            e = q8.pop_front();
            checks++;
            ce = 1'b0;
`ifdef DEMUX_ROUTER_SEL_ERR_EN
            ce = e.err;
`endif
            if ({d8_out_data, d8_out_strb, d8_rr_ptr, d8_err} !== {e.data[7:0], e.strb, e.ptr, ce}) begin
                errors++;
                $display("FAIL %s: got data=%h strb=%h ptr=%0d err=%b, want data=%h strb=%h ptr=%0d err=%b",
                         e.name, d8_out_data, d8_out_strb, d8_rr_ptr, d8_err,
                         e.data[7:0], e.strb, e.ptr, ce);
            end
        end
        if (q6.size() > 0) begin
            e = q6.pop_front();
            checks++;
            ce = 1'b0;
`ifdef DEMUX_ROUTER_SEL_ERR_EN
            ce = e.err;
`endif
            if ({d6_out_data, d6_out_strb, d6_rr_ptr, d6_err} !== {e.data[23:0], e.strb[5:0], e.ptr, ce}) begin
                errors++;
                $display("FAIL %s: got data=%h strb=%h ptr=%0d err=%b, want data=%h strb=%h ptr=%0d err=%b",
                         e.name, d6_out_data, d6_out_strb, d6_rr_ptr, d6_err,
                         e.data[23:0], e.strb[5:0], e.ptr, ce);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] t;
        c_rr_data = '{24'h000001, 24'h000021, 24'h000321, 24'h004321,
                      24'h054321, 24'h654321, 24'h654327};
        c_rr_strb = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
        c_rr_ptr  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};

        d8_rst = 1'b1; d8_valid = 1'b0; d8_data = '0; d8_sel = '0;
        d8_rr = 1'b0; d8_hold = 1'b1; d8_clr = 1'b0;
        d6_rst = 1'b1; d6_valid = 1'b0; d6_data = '0; d6_sel = '0;
        d6_rr = 1'b0; d6_hold = 1'b1; d6_clr = 1'b0;

        // ---- 8 x 1: reset, hold sweep, clear sweep, back-to-back ----
        step8(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, "d8_reset");
        step8(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, "d8_reset2");
        for (int k = 0; k < 8; k++) begin
            t = (9'd1 << (k + 1)) - 9'd1;
            step8(1'b1, 1'b1, 3'(k), 1'b0, 1'b1, 1'b0, 1'b0, t[7:0], 8'd1 << k, 3'd0,
                  $sformatf("d8_hold_sel%0d", k));
        end
        step8(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 3'd0, "d8_idle");
        for (int k = 0; k < 8; k++) begin
            step8(1'b1, 1'b1, 3'(k), 1'b0, 1'b0, 1'b0, 1'b0, 8'd1 << k, 8'd1 << k, 3'd0,
                  $sformatf("d8_zero_sel%0d", k));
        end
        step8(1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h88, 8'h08, 3'd0, "d8_b2b_1");
        step8(1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h88, 8'h08, 3'd0, "d8_b2b_2");
        step8(1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h08, 3'd0, "d8_b2b_data0");
        step8(1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 8'h01, 3'd1, "d8_rr_first");
        step8(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h81, 8'h00, 3'd1, "d8_idle2");

        // ---- 6 x 4: reset, round-robin wrap ----
        step6(1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0, 6'h00, 3'd0, 1'b0, "d6_reset");
        for (int v = 1; v <= 7; v++) begin
            step6(1'b1, 4'(v), 3'd0, 1'b1, 1'b1, 1'b0, 1'b0,
                  c_rr_data[v-1], c_rr_strb[v-1], c_rr_ptr[v-1], 1'b0,
                  $sformatf("d6_rr_write%0d", v));
        end
        // Out-of-range selects are dropped even with hold_en=0.
        step6(1'b1, 4'h9, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 24'h654327, 6'h00, 3'd1, 1'b1, "d6_sel7_drop");
        step6(1'b1, 4'h9, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 24'h654327, 6'h00, 3'd1, 1'b1, "d6_sel6_drop");
        // rr_en toggling keeps the pointer.
        step6(1'b1, 4'hA, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 24'h654A27, 6'h04, 3'd1, 1'b1, "d6_toggle_sel2");
        step6(1'b1, 4'hB, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h654AB7, 6'h02, 3'd2, 1'b1, "d6_toggle_rr1");
        step6(1'b1, 4'hC, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h654CB7, 6'h04, 3'd3, 1'b1, "d6_toggle_rr2");
        // clr with a same-cycle write and rr_ptr=3.
        step6(1'b1, 4'hF, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 6'h00, 3'd0, 1'b1, "d6_clr_write");
        step6(1'b1, 4'h5, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000005, 6'h01, 3'd1, 1'b1, "d6_after_clr1");
        step6(1'b1, 4'h6, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000065, 6'h02, 3'd2, 1'b1, "d6_after_clr2");
        // Reset mid-stream loses that cycle's write; writes resume at channel 0.
        step6(1'b1, 4'h7, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000000, 6'h00, 3'd0, 1'b0, "d6_rst_stream");
        step6(1'b1, 4'h8, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000008, 6'h01, 3'd1, 1'b0, "d6_after_rst");
        step6(1'b1, 4'h9, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000090, 6'h02, 3'd2, 1'b0, "d6_rr_zero_others");
        step6(1'b0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000090, 6'h00, 3'd2, 1'b0, "d6_idle");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ((q8.size() + q6.size()) != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q8.size() + q6.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_router.md
# demux_router

Registered, parametrised 1-to-N demultiplexer that routes a WIDTH-bit sample to one of NUM_CH output channels, with per-write strobes, a hold/clear mode for non-target channels and a round-robin auto-select mode. It sits between the note/gate source and the bank of ADSR envelope channels, replacing the fixed 8-output 1-bit combinational demux. Each accepted write is steered to one envelope channel, either by explicit select or by round-robin assignment.

## Interface
- NUM_CH, 8: number of output channels, legal 2..32, need not be a power of 2.
- WIDTH, 1: data width per channel, legal 1..32.
- SEL_W, $clog2(NUM_CH): derived localparam, not overridable.

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  write request for this cycle.
- in_data  in  WIDTH  sample to route.
- sel  in  SEL_W  explicit target channel, used when rr_en=0.
- rr_en  in  1  1 = target is rr_ptr; 0 = target is sel.
- hold_en  in  1  1 = non-target channels keep value on a write; 0 = non-target channels are zeroed on a write.
- clr  in  1  synchronous clear of all channels and the pointer.
- out_data  out  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_strb  out  NUM_CH  one-hot, one-cycle pulse marking the channel written last cycle.
- rr_ptr  out  SEL_W  next round-robin target.
- sel_err  out  1  sticky out-of-range select flag; present only with DEMUX_ROUTER_SEL_ERR_EN.

## Operation
- target = rr_en ? rr_ptr : sel.
- A write is accepted when in_valid=1, clr=0, and target < NUM_CH.
- On an accepted write:
  - out_data[target] <= in_data.
  - out_strb <= onehot(target).
  - Non-target slices hold if hold_en=1 and are set to 0 if hold_en=0.
- When no write is accepted: out_data holds and out_strb <= 0.
- Round-robin pointer:
  - Increments after each accepted write made with rr_en=1.
  - Wraps from NUM_CH-1 to 0.
  - Unchanged when rr_en=0 or when no write is accepted.
- Out-of-range select (sel >= NUM_CH, possible only for non-power-of-2 NUM_CH):
  - The write is dropped, no strobe is issued, and out_data and rr_ptr are unchanged.
  - rr_ptr never holds an out-of-range value.
- Priority: rst > clr > write. clr=1 zeroes out_data, out_strb and rr_ptr. A write in the same cycle is discarded, and sel_err is not cleared by clr.
- rr_en may toggle any cycle. A toggle takes effect on that cycle's write and the pointer is retained across toggles.

## Timing
- Reset values: out_data=0, out_strb=0, rr_ptr=0, sel_err=0.
- Latency is 1 cycle: a write accepted at edge n appears on out_data and out_strb after edge n.
- Throughput is one write per cycle. Back-to-back writes to the same channel produce out_strb on consecutive cycles.
- out_strb is high for exactly one cycle per accepted write.
- Reset asserted mid-stream takes effect at the next edge, and the write in that cycle is lost.
- No combinational path from inputs to outputs.

## Configuration
- DEMUX_ROUTER_SEL_ERR_EN defined:
  - sel_err is set on the first edge at which in_valid=1, clr=0 and an out-of-range sel is used with rr_en=0.
  - sel_err stays set until rst.
- DEMUX_ROUTER_SEL_ERR_EN undefined:
  - The sel_err port and its register are absent.
  - Out-of-range writes are dropped silently, with identical data behaviour.

## Structure
- Package demux_router_pkg holds:
  - the NUM_CH/WIDTH legal-range constants;
  - a function returning the one-hot vector for a channel index;
  - a function computing rr_ptr wrap.
- Sub-module demux_onehot_dec (index + enable in, NUM_CH one-hot out, enable low or index out of range gives all-zero) is shared between the strobe and write-enable logic.
- Top level instantiates one demux_onehot_dec and NUM_CH WIDTH-bit registers via generate.

## Test plan
- NUM_CH=8, WIDTH=1, rr_en=0, hold_en=1; sweep sel 0..7 with in_data=1 -> each channel goes to 1 in turn, out_strb = 8'h01..8'h80 one cycle after each write, earlier channels stay 1.
- Same sweep with hold_en=0 -> after each write only the target channel is 1, all others 0.
- NUM_CH=6, WIDTH=4, rr_en=1; 7 writes of values 1..7 -> channels 0..5 = 1..6, then channel 0 = 7; rr_ptr sequence 1,2,3,4,5,0,1.
- NUM_CH=6, rr_en=0, sel=7, in_valid=1 -> no strobe, out_data unchanged; sel_err=1 with the macro defined, port absent without it.
- clr and in_valid together with rr_ptr=3 -> out_data=0, out_strb=0, rr_ptr=0 next cycle; the write is discarded.
- rst asserted for 1 cycle during a continuous write stream -> all outputs 0 after that edge; writes resume at channel 0 in round-robin mode.
